// File: rtl/count_pkg.sv
// Shared types and limits for the count_ctrl counter, its decoder stage and bench.
package count_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [4:0] COUNT_MAX = 5'd19;

  // Returns {wrap, next_count} for a single up or down step over 0..COUNT_MAX.
  function automatic logic [5:0] step_count(input logic [4:0] c, input logic down);
    logic [5:0] r;
    if (down) begin
      r = (c == 5'd0) ? {1'b1, COUNT_MAX} : {1'b0, c - 5'd1};
    end else begin
      r = (c >= COUNT_MAX) ? {1'b1, 5'd0} : {1'b0, c + 5'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Button/switch inputs and counter outputs of count_ctrl, grouped as one bundle.
interface count_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       dir_down;
  logic [4:0] count;
  logic       running;
  logic       wrap;

  modport master (
    output btn_start, btn_clear, dir_down,
    input  count, running, wrap
  );

  modport slave (
    input  btn_start, btn_clear, dir_down,
    output count, running, wrap
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and registered rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] STAB_LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] stab;
  logic          level_q;
  logic          level_d;
  logic          rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b0;
      sync    <= 1'b0;
      stab    <= '0;
      level_q <= 1'b0;
      level_d <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      // Level follows only after DEB_CYCLES consecutive disagreeing samples.
      if (sync != level_q) begin
        if (stab == STAB_LAST) begin
          level_q <= sync;
          stab    <= '0;
        end else begin
          stab <= stab + CW'(1);
        end
      end else begin
        stab <= '0;
      end
      level_d <= level_q;
      rise_q  <= level_q & ~level_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/count_ctrl.sv
// Run/stop 0..19 up/down counter stepped by a TICK_DIV prescaler, with debounced controls.
module count_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  count_ctrl_if.slave  bus
);

  import count_pkg::*;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_level;
  logic start_rise;
  logic clear_level;
  logic clear_rise;
  logic dir_level;
  logic dir_rise;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_start),
    .level (start_level),
    .rise  (start_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_clear),
    .level (clear_level),
    .rise  (clear_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dir (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.dir_down),
    .level (dir_level),
    .rise  (dir_rise)
  );

  state_t        state_q;
  state_t        state_n;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_n;
  logic [4:0]    count_q;
  logic [4:0]    count_n;
  logic          wrap_q;
  logic          wrap_n;
  logic          running_q;

  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    count_n = count_q;
    wrap_n  = 1'b0;

    if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_n           = '0;
        {wrap_n, count_n} = step_count(count_q, dir_level);
      end else begin
        presc_n = presc_q + PW'(1);
      end
    end

    if (start_rise) begin
      state_n = (state_q == RUN) ? STOP : RUN;
    end

    // Clear overrides any step or start toggle landing on the same edge.
    if (clear_rise) begin
      state_n = STOP;
      presc_n = '0;
      count_n = '0;
      wrap_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      presc_q   <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      presc_q   <= presc_n;
      count_q   <= count_n;
      wrap_q    <= wrap_n;
      running_q <= (state_n == RUN);
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: expected output events are queued and a monitor checks them.
module tb_count_ctrl;
  import count_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_ctrl_if bus();

  count_ctrl #(.TICK_DIV(5), .DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  cnt;
    logic        run;
    logic        wr;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  mon_done = 1'b0;

  task automatic expect_ev(input int unsigned c, input logic [4:0] n, input logic r, input logic w);
    ev_t e;
    e.cyc = c;
    e.cnt = n;
    e.run = r;
    e.wr  = w;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Any change of {count, running, wrap} is an output event matched against the queue.
  initial begin
    logic [6:0] prev;
    logic [6:0] cur;
    ev_t        e;
    wait (mon_en);
    prev = {bus.count, bus.running, bus.wrap};
    while (!mon_done) begin
      @(negedge clk);
      cur = {bus.count, bus.running, bus.wrap};
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual cyc=%0d count=%0d running=%0d wrap=%0d required none",
                   cyc, cur[6:2], cur[1], cur[0]);
        end else begin
          e = q.pop_front();
          if ({cyc, cur} !== {e.cyc, e.cnt, e.run, e.wr}) begin
            errors++;
            $display("FAIL event actual cyc=%0d count=%0d running=%0d wrap=%0d required cyc=%0d count=%0d running=%0d wrap=%0d",
                     cyc, cur[6:2], cur[1], cur[0], e.cyc, e.cnt, e.run, e.wr);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int unsigned k0;
    int unsigned k;
    int unsigned p;
    ev_t         e;

    rst           = 1'b1;
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    bus.dir_down  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_count",   32'(bus.count),   32'd0);
    check("reset_running", 32'(bus.running), 32'd0);
    check("reset_wrap",    32'(bus.wrap),    32'd0);

    rst           = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    bus.dir_down  = 1'b0;
    mon_en        = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_running", 32'(bus.running), 32'd0);
    check("post_reset_count",   32'(bus.count),   32'd0);

    // Bounce on start, then a stable press: one toggle to RUN 8 cycles later.
    k0 = cyc;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(k0 + 2 * i);
      bus.btn_start = (i % 2 == 0);
    end
    k = k0 + 12;
    wait_cyc(k);
    bus.btn_start = 1'b1;

    expect_ev(k + 8, 5'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 19; i++) expect_ev(k + 8 + 5 * i, 5'(i), 1'b1, 1'b0);
    expect_ev(k + 108, 5'd0, 1'b1, 1'b1);
    expect_ev(k + 109, 5'd0, 1'b1, 1'b0);
    expect_ev(k + 113, 5'd1, 1'b1, 1'b0);
    expect_ev(k + 118, 5'd0, 1'b1, 1'b0);
    expect_ev(k + 123, COUNT_MAX, 1'b1, 1'b1);
    expect_ev(k + 124, 5'd19, 1'b1, 1'b0);
    for (int c = 18; c >= 7; c--) expect_ev(k + 128 + 5 * (18 - c), 5'(c), 1'b1, 1'b0);
    expect_ev(k + 188, 5'd0, 1'b0, 1'b0);

    wait_cyc(k + 10);
    bus.btn_start = 1'b0;
    // Debounced direction lands at k+115, between the steps at k+113 and k+118.
    wait_cyc(k + 109);
    bus.dir_down = 1'b1;
    // Both pulses arrive together on the count=7 step edge at k+188.
    wait_cyc(k + 180);
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    wait_cyc(k + 190);
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;

    // Pause: stop on the edge where prescaler is 3, resume 28 cycles later.
    p = k + 200;
    expect_ev(p + 8,  5'd0,  1'b1, 1'b0);
    expect_ev(p + 13, 5'd19, 1'b1, 1'b1);
    expect_ev(p + 14, 5'd19, 1'b1, 1'b0);
    expect_ev(p + 18, 5'd18, 1'b1, 1'b0);
    expect_ev(p + 22, 5'd18, 1'b0, 1'b0);
    expect_ev(p + 50, 5'd18, 1'b1, 1'b0);
    expect_ev(p + 51, 5'd17, 1'b1, 1'b0);
    expect_ev(p + 56, 5'd16, 1'b1, 1'b0);

    wait_cyc(p);
    bus.btn_start = 1'b1;
    wait_cyc(p + 6);
    bus.btn_start = 1'b0;
    wait_cyc(p + 14);
    bus.btn_start = 1'b1;
    wait_cyc(p + 26);
    bus.btn_start = 1'b0;
    wait_cyc(p + 42);
    bus.btn_start = 1'b1;
    wait_cyc(p + 48);
    bus.btn_start = 1'b0;

    wait_cyc(p + 60);
    mon_done = 1'b1;
    repeat (2) @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event actual none required cyc=%0d count=%0d running=%0d wrap=%0d",
               e.cyc, e.cnt, e.run, e.wr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
